onchip_mem_arbiter: RTL and testbench
=====================================

Name: onchip_mem_arbiter

Overview:
- Two-master arbiter and sequencer in front of the 8192x32 single-port on-chip RAM (13-bit word address, 4 byte enables, 1-cycle read latency).
- Lets the Nios data master (m0) and the UART RX/TX DMA engine (m1) share the RAM through Avalon-MM slave ports with waitrequest and readdatavalid.
- Issues at most one RAM access per clock using round-robin arbitration, and routes read data back to the master that issued the read.

Parameters:
- ADDR_W, 13, word-address width passed to the RAM.
- DATA_W, 32, data width; byte-enable width = DATA_W/8.
- MAX_LOCK, 16, maximum consecutive grants to one master while locked (optional feature only).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- m0_address  in  ADDR_W  master 0 word address.
- m0_byteenable  in  DATA_W/8  master 0 byte enables.
- m0_read  in  1  master 0 read request.
- m0_write  in  1  master 0 write request.
- m0_writedata  in  DATA_W  master 0 write data.
- m0_waitrequest  out  1  master 0 stall; combinational.
- m0_readdata  out  DATA_W  master 0 read data.
- m0_readdatavalid  out  1  master 0 read data qualifier.
- m1_*  same set as m0_*  master 1 (DMA).
- mem_address  out  ADDR_W  RAM address.
- mem_byteenable  out  DATA_W/8  RAM byte enables.
- mem_chipselect  out  1  RAM select.
- mem_write  out  1  RAM write.
- mem_writedata  out  DATA_W  RAM write data.
- mem_clken  out  1  RAM clock enable; constant 1.
- mem_reset_req  out  1  RAM reset request; constant 0.
- mem_readdata  in  DATA_W  RAM read data, valid 1 cycle after the read is issued.

Behaviour:
- Request definition: reqN = mN_read | mN_write. If read and write are both high, treat it as a write.
- Grant: combinational each cycle from req0, req1 and the registered priority pointer `last`.
  - Only one requesting: that master wins.
  - Both requesting: the master != `last` wins.
  - Reset value of `last` = 1, so m0 wins the first tie.
- On grant to N:
  - mem_* driven from mN_*; mem_chipselect = 1; mem_write = mN_write.
  - mN_waitrequest = 0; the access completes that cycle.
  - `last` <= N at the clock edge.
- Non-granted requesting master: waitrequest = 1. A non-requesting master sees waitrequest = 0 (don't care).
- Idle (no request): mem_chipselect = 0, mem_write = 0; mem_address/byteenable/writedata hold the m0 values; `last` unchanged.
- Read return pipeline: registers rd_vld and rd_owner.
  - rd_vld <= granted & read; rd_owner <= granted master index.
  - Next cycle: mN_readdatavalid = rd_vld & (rd_owner == N); mN_readdata = mem_readdata for both masters.
  - Read latency = 1 cycle after the accepted (waitrequest = 0) cycle.
- Back-to-back: one access per cycle, with no bubbles between grants. Sustained contention alternates m0, m1, m0, …
- Simultaneous events:
  - A new read may be issued in the same cycle the previous read's data returns.
  - A write issued the cycle after a read does not corrupt that read's returned data.
- Reset: synchronous. Values at the reset edge:
  - rd_vld = 0, readdatavalid = 0, `last` = 1, lock state cleared.
  - While reset = 1, no grant is issued: mem_chipselect = 0, mem_write = 0, both waitrequests = 1.
  - A read accepted in the cycle before reset asserts has its readdatavalid suppressed.
- Throughput: no outstanding-transaction limit beyond the 1-deep read pipe.

Optional Feature:
- Macro: ONCHIP_ARB_LOCK_EN.
- With the macro defined:
  - Adds inputs m0_lock and m1_lock (1 bit each).
  - If granted master N asserts mN_lock with its request, it keeps priority on later ties while lock stays high. Concretely, `last` is not advanced past N.
  - Priority is held for at most MAX_LOCK consecutive grants. A 5-bit counter tracks grants; at the limit the other master wins the next tie, then the counter clears.
  - The counter also clears when lock drops or when the other master is granted.
- Without the macro: no lock ports and no counter; pure round-robin.

Test Plan:
- After reset, m0 writes 0xDEADBEEF to address 0x0010 with byteenable 0xF and waitrequest = 0; one cycle later m0 reads 0x0010 -> m0_readdatavalid = 1 exactly one cycle after acceptance with m0_readdata = 0xDEADBEEF; m1_readdatavalid stays 0.
- m0 and m1 both read continuously for 8 cycles -> grants alternate m0, m1, m0, … starting with m0; each master sees 4 readdatavalid pulses; mem_chipselect = 1 every cycle.
- m1 writes 0x000000AA to 0x1FFF with byteenable 0x1 after 0x12345678 was written there -> a subsequent read returns 0x123456AA; address 0x1FFF is accepted with no wrap error.
- m0 read accepted, then reset asserted on the next cycle -> m0_readdatavalid = 0, mem_chipselect = 0, both waitrequests = 1 during reset; after reset a tie grants m0 first.
- With ONCHIP_ARB_LOCK_EN and MAX_LOCK = 4: m1 holds lock while both master requests are held for 10 cycles -> grant order m1, m1, m1, m1, m0, m1, m1, m1, m1, m0.
- Idle bus for 5 cycles -> mem_chipselect = 0, mem_write = 0, no readdatavalid, mem_clken = 1, mem_reset_req = 0.

Source files
------------

// File: rtl/onchip_mem_arbiter.sv
// Round-robin arbiter that lets two Avalon-MM masters share one single-port RAM.
// Define ONCHIP_ARB_LOCK_EN to add per-master lock inputs with bounded priority hold.
module onchip_mem_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
`ifdef ONCHIP_ARB_LOCK_EN
  , parameter int MAX_LOCK = 16
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
`ifdef ONCHIP_ARB_LOCK_EN
  input  logic                m0_lock,
  input  logic                m1_lock,
`endif
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  output logic                mem_reset_req,
  input  logic [DATA_W-1:0]   mem_readdata
);

  logic req0, req1, gnt0, gnt1, rd_go;
  logic last;      // master granted most recently; the other one wins a tie
  logic rd_vld;
  logic rd_owner;

  // Handshake: a request (read or write high) is accepted in the cycle where
  // waitrequest is low; read data follows exactly one cycle later with readdatavalid.
  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;
  assign gnt0 = !reset & req0 & (!req1 | last);
  assign gnt1 = !reset & req1 & (!req0 | !last);

  assign m0_waitrequest = reset | (req0 & !gnt0);
  assign m1_waitrequest = reset | (req1 & !gnt1);

  // Idle cycles leave the m0 values on the RAM bus.
  assign mem_address    = gnt1 ? m1_address    : m0_address;
  assign mem_byteenable = gnt1 ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = gnt1 ? m1_writedata  : m0_writedata;
  assign mem_chipselect = gnt0 | gnt1;
  assign mem_write      = (gnt0 & m0_write) | (gnt1 & m1_write);
  assign mem_clken      = 1'b1;
  assign mem_reset_req  = 1'b0;

  // A request with both read and write high counts as a write.
  assign rd_go = (gnt0 & m0_read & !m0_write) | (gnt1 & m1_read & !m1_write);

  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign m0_readdatavalid = rd_vld & !rd_owner & !reset;
  assign m1_readdatavalid = rd_vld &  rd_owner & !reset;

`ifdef ONCHIP_ARB_LOCK_EN
  logic [4:0] lock_cnt;
  logic       lock_owner;
  logic       gnt_lock;
  logic [4:0] cnt_base;

  assign gnt_lock = (gnt0 & m0_lock) | (gnt1 & m1_lock);
  // A run of locked grants restarts whenever the other master gets the bus.
  assign cnt_base = (lock_owner == gnt1) ? lock_cnt : 5'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld     <= 1'b0;
      rd_owner   <= 1'b0;
      last       <= 1'b1;
      lock_cnt   <= 5'd0;
      lock_owner <= 1'b0;
    end else begin
      rd_vld <= rd_go;
      if (gnt0 | gnt1) begin
        rd_owner   <= gnt1;
        lock_owner <= gnt1;
        if (gnt_lock && ((cnt_base + 5'd1) < 5'(MAX_LOCK))) begin
          last     <= gnt0;
          lock_cnt <= cnt_base + 5'd1;
        end else begin
          last     <= gnt1;
          lock_cnt <= 5'd0;
        end
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld   <= 1'b0;
      rd_owner <= 1'b0;
      last     <= 1'b1;
    end else begin
      rd_vld <= rd_go;
      if (gnt0 | gnt1) begin
        rd_owner <= gnt1;
        last     <= gnt1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: directed vector table, a reset corner sequence,
// then randomized traffic checked against a transaction-level reference model.
module tb_onchip_mem_arbiter;
  localparam int AW = 13;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] m0_address = '0, m1_address = '0;
  logic [3:0]    m0_byteenable = '0, m1_byteenable = '0;
  logic          m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [DW-1:0] m0_writedata = '0, m1_writedata = '0;
  logic          m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [DW-1:0] m0_readdata, m1_readdata;
  logic [AW-1:0] mem_address;
  logic [3:0]    mem_byteenable;
  logic          mem_chipselect, mem_write, mem_clken, mem_reset_req;
  logic [DW-1:0] mem_writedata;
  logic [DW-1:0] mem_readdata = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  onchip_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_reset_req(mem_reset_req), .mem_readdata(mem_readdata)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  // RAM stand-in: single port, one-cycle registered read.
  logic [31:0] ram [0:8191];
  initial for (int i = 0; i < 8192; i++) ram[i] = '0;
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (mem_write) ram[mem_address] <= merge(ram[mem_address], mem_writedata, mem_byteenable);
      else mem_readdata <= ram[mem_address];
    end
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endfunction

  typedef struct {
    logic rst;
    logic r0, w0; logic [AW-1:0] a0; logic [31:0] d0; logic [3:0] be0;
    logic r1, w1; logic [AW-1:0] a1; logic [31:0] d1; logic [3:0] be1;
    int gnt;                 // -1 none, 0 m0, 1 m1
    logic rv0, rv1; logic [31:0] rdata;
  } vec_t;

  function automatic vec_t mk(input logic rst,
      input logic r0, input logic w0, input logic [AW-1:0] a0, input logic [31:0] d0, input logic [3:0] be0,
      input logic r1, input logic w1, input logic [AW-1:0] a1, input logic [31:0] d1, input logic [3:0] be1,
      input int gnt, input logic rv0, input logic rv1, input logic [31:0] rdata);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0; v.be0 = be0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.be1 = be1;
    v.gnt = gnt; v.rv0 = rv0; v.rv1 = rv1; v.rdata = rdata;
    return v;
  endfunction

  task automatic set_inputs(input vec_t v);
    reset = v.rst;
    m0_read = v.r0; m0_write = v.w0; m0_address = v.a0; m0_writedata = v.d0; m0_byteenable = v.be0;
    m1_read = v.r1; m1_write = v.w1; m1_address = v.a1; m1_writedata = v.d1; m1_byteenable = v.be1;
  endtask

  task automatic run_row(input vec_t v, input string tag);
    logic ew;
    set_inputs(v);
    @(negedge clk);
    ew = (v.gnt == 0) ? v.w0 : (v.gnt == 1) ? v.w1 : 1'b0;
    chk({tag, ".wait0"}, 32'(m0_waitrequest), 32'(v.rst | ((v.r0 | v.w0) & (v.gnt != 0))));
    chk({tag, ".wait1"}, 32'(m1_waitrequest), 32'(v.rst | ((v.r1 | v.w1) & (v.gnt != 1))));
    chk({tag, ".cs"}, 32'(mem_chipselect), 32'(v.gnt >= 0));
    chk({tag, ".mem_write"}, 32'(mem_write), 32'(ew));
    chk({tag, ".addr"}, 32'(mem_address), 32'((v.gnt == 1) ? v.a1 : v.a0));
    if (v.gnt >= 0) begin
      chk({tag, ".be"}, 32'(mem_byteenable), 32'((v.gnt == 1) ? v.be1 : v.be0));
      chk({tag, ".wdata"}, mem_writedata, (v.gnt == 1) ? v.d1 : v.d0);
    end
    chk({tag, ".rv0"}, 32'(m0_readdatavalid), 32'(v.rv0));
    chk({tag, ".rv1"}, 32'(m1_readdatavalid), 32'(v.rv1));
    if (v.rv0) chk({tag, ".rdata0"}, m0_readdata, v.rdata);
    if (v.rv1) chk({tag, ".rdata1"}, m1_readdata, v.rdata);
    chk({tag, ".clken"}, 32'(mem_clken), 32'd1);
    chk({tag, ".reset_req"}, 32'(mem_reset_req), 32'd0);
    @(posedge clk); #1;
  endtask

  // Reference model state: pointer, shadow memory, pending read data and owner.
  int          m_last;
  logic [31:0] ref_mem [0:8191];
  logic [DW-1:0] exp_q[$];
  int          own_q[$];

  vec_t tbl[$];
  vec_t rv;

  initial begin
    for (int i = 0; i < 8192; i++) ref_mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;

    tbl.push_back(mk(1, 1,0,13'h0,0,4'h0,       1,0,13'h0,0,4'h0, -1, 0,0,0));
    tbl.push_back(mk(0, 0,1,13'h10,32'hDEADBEEF,4'hF, 0,0,13'h0,0,4'h0, 0, 0,0,0));
    tbl.push_back(mk(0, 1,0,13'h10,0,4'hF,      0,0,13'h0,0,4'h0, 0, 0,0,0));
    tbl.push_back(mk(0, 0,0,13'h0,0,4'h0,       0,0,13'h0,0,4'h0, -1, 1,0,32'hDEADBEEF));
    tbl.push_back(mk(1, 0,0,13'h0,0,4'h0,       0,0,13'h0,0,4'h0, -1, 0,0,0));
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(0, 1,0,13'h10,0,4'hF, 1,0,13'h20,0,4'hF, k % 2,
                       (k % 2) == 1, (k > 0) && ((k % 2) == 0),
                       ((k % 2) == 1) ? 32'hDEADBEEF : 32'h0));
    tbl.push_back(mk(0, 0,0,13'h0,0,4'h0,       0,0,13'h0,0,4'h0, -1, 0,1,32'h0));
    tbl.push_back(mk(0, 0,0,13'h0,0,4'h0,       0,1,13'h1FFF,32'h12345678,4'hF, 1, 0,0,0));
    tbl.push_back(mk(0, 0,0,13'h0,0,4'h0,       0,1,13'h1FFF,32'h000000AA,4'h1, 1, 0,0,0));
    tbl.push_back(mk(0, 1,0,13'h1FFF,0,4'hF,    0,0,13'h0,0,4'h0, 0, 0,0,0));
    tbl.push_back(mk(0, 0,0,13'h0,0,4'h0,       0,0,13'h0,0,4'h0, -1, 1,0,32'h123456AA));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(0, 0,0,13'h0,0,4'h0,     0,0,13'h0,0,4'h0, -1, 0,0,0));

    for (int i = 0; i < tbl.size(); i++) run_row(tbl[i], $sformatf("row%0d", i));

    // Read accepted, then reset: the returning data must not be flagged valid.
    run_row(mk(0, 1,0,13'h10,0,4'hF, 0,0,13'h0,0,4'h0, 0, 0,0,0), "rst_seq.accept");
    run_row(mk(1, 1,0,13'h10,0,4'hF, 1,0,13'h20,0,4'hF, -1, 0,0,0), "rst_seq.in_reset");
    run_row(mk(0, 1,0,13'h10,0,4'hF, 1,0,13'h20,0,4'hF, 0, 0,0,0), "rst_seq.first_tie");
    run_row(mk(0, 0,0,13'h0,0,4'h0,  0,0,13'h0,0,4'h0, -1, 1,0,32'hDEADBEEF), "rst_seq.data");

    // Randomized traffic on an address window the directed rows never touched.
    run_row(mk(1, 0,0,13'h0,0,4'h0, 0,0,13'h0,0,4'h0, -1, 0,0,0), "rnd.reset");
    m_last = 1;
    for (int c = 0; c < 400; c++) begin
      int g;
      logic q0, q1, have, rd;
      logic [31:0] ed;
      int eo;
      logic [AW-1:0] ga;
      rv = mk($urandom_range(0, 39) == 0,
              1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, 13'(13'h100 + $urandom_range(0, 7)),
              $urandom, 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, 13'(13'h100 + $urandom_range(0, 7)),
              $urandom, 4'($urandom_range(0, 15)), -1, 0, 0, 0);
      set_inputs(rv);
      @(negedge clk);
      q0 = rv.r0 | rv.w0;
      q1 = rv.r1 | rv.w1;
      if (rv.rst) g = -1;
      else if (q0 && q1) g = (m_last == 1) ? 0 : 1;
      else if (q0) g = 0;
      else if (q1) g = 1;
      else g = -1;
      have = 1'b0; ed = '0; eo = 0;
      if (exp_q.size() > 0) begin
        ed = exp_q.pop_front();
        eo = own_q.pop_front();
        have = !rv.rst;
      end
      chk($sformatf("rnd%0d.wait0", c), 32'(m0_waitrequest), 32'(rv.rst | (q0 & (g != 0))));
      chk($sformatf("rnd%0d.wait1", c), 32'(m1_waitrequest), 32'(rv.rst | (q1 & (g != 1))));
      chk($sformatf("rnd%0d.cs", c), 32'(mem_chipselect), 32'(g >= 0));
      chk($sformatf("rnd%0d.rv0", c), 32'(m0_readdatavalid), 32'(have && eo == 0));
      chk($sformatf("rnd%0d.rv1", c), 32'(m1_readdatavalid), 32'(have && eo == 1));
      if (have) chk($sformatf("rnd%0d.rdata", c), (eo == 0) ? m0_readdata : m1_readdata, ed);
      if (g >= 0) begin
        ga = (g == 0) ? rv.a0 : rv.a1;
        rd = (g == 0) ? (rv.r0 & !rv.w0) : (rv.r1 & !rv.w1);
        chk($sformatf("rnd%0d.mem_write", c), 32'(mem_write), 32'(!rd));
        chk($sformatf("rnd%0d.addr", c), 32'(mem_address), 32'(ga));
        if (rd) begin
          exp_q.push_back(ref_mem[ga]);
          own_q.push_back(g);
        end else begin
          chk($sformatf("rnd%0d.wdata", c), mem_writedata, (g == 0) ? rv.d0 : rv.d1);
          ref_mem[ga] = merge(ref_mem[ga], (g == 0) ? rv.d0 : rv.d1, (g == 0) ? rv.be0 : rv.be1);
        end
        m_last = g;
      end else begin
        chk($sformatf("rnd%0d.mem_write", c), 32'(mem_write), 32'd0);
      end
      if (rv.rst) m_last = 1;
      @(posedge clk); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
